// File: rtl/shared_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : shared_pkg
//  Purpose  : Shared types and constants for the SPI slave / RAM slice.
//  Revision : 1.0  initial release
// ============================================================================
package shared_pkg;

    // RAM data width; SPI words carry a 2-bit opcode on top of this.
    localparam int MEM_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } spi_state_e;

    // Opcodes carried in rx_data[9:8]; decoded by the RAM, not by the slave.
    localparam logic [1:0] WR_ADDR = 2'b00;
    localparam logic [1:0] WR_DATA = 2'b01;
    localparam logic [1:0] RD_ADDR = 2'b10;
    localparam logic [1:0] RD_DATA = 2'b11;

endpackage
`default_nettype wire

// File: rtl/spi_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : spi_tx_serializer
//  Purpose  : Loads one RAM read word and shifts it out MSB first, then
//             returns the line to 0 and flags completion.
//  Revision : 1.0  initial release
// ============================================================================
module spi_tx_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_serial,
    output logic             o_done
);

    localparam int                 c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    logic [WIDTH-1:0]   r_shift;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_busy;
    logic               r_serial;

    // Completion is the edge that drives the line back to 0 after the LSB.
    assign o_done   = r_busy && (r_cnt == c_last) && !i_clear;
    assign o_serial = r_serial;

    // Load puts the MSB on the line immediately; each later edge advances one bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift  <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_serial <= 1'b0;
        end else if (i_clear) begin
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_serial <= 1'b0;
        end else if (i_load && !r_busy) begin
            r_shift  <= {i_data[WIDTH-2:0], 1'b0};
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_serial <= i_data[WIDTH-1];
        end else if (r_busy) begin
            if (r_cnt == c_last) begin
                r_busy   <= 1'b0;
                r_serial <= 1'b0;
            end else begin
                r_serial <= r_shift[WIDTH-1];
                r_shift  <= {r_shift[WIDTH-2:0], 1'b0};
                r_cnt    <= r_cnt + c_cnt_w'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_slave_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave_ctrl
//  Purpose  : SPI slave front-end for the single-port RAM. Deserialises MOSI
//             frames into {opcode, payload} words and serialises RAM read
//             data onto MISO.
//  Revision : 1.0  initial release
// ============================================================================
module spi_slave_ctrl #(
    parameter int MEM_WIDTH = shared_pkg::MEM_WIDTH,
    parameter int CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 SS_n,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic [MEM_WIDTH+1:0] rx_data,
    output logic                 rx_valid,
    input  logic [MEM_WIDTH-1:0] tx_data,
    input  logic                 tx_valid
);

    import shared_pkg::*;

    // Index of the last word bit, and the count meaning "word complete".
    localparam logic [CNT_W-1:0] c_last_bit   = CNT_W'(MEM_WIDTH + 1);
    localparam logic [CNT_W-1:0] c_word_count = CNT_W'(MEM_WIDTH + 2);

    spi_state_e           r_state;
    spi_state_e           w_next_state;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [MEM_WIDTH:0]   r_rx_shift;
    logic [MEM_WIDTH+1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_rd_addr_seen;
    logic                 r_tx_armed;

    logic w_data_state;
    logic w_shift_en;
    logic w_word_done;
    logic w_tx_load;
    logic w_tx_done;
    logic w_miso;

    assign w_data_state = (r_state == WRITE) || (r_state == READ_ADD) ||
                          (r_state == READ_DATA);
    // Bits past the word length in the same frame are ignored.
    assign w_shift_en   = !SS_n && w_data_state && (r_bit_cnt < c_word_count);
    assign w_word_done  = w_shift_en && (r_bit_cnt == c_last_bit);
    // tx_valid only counts while a READ_DATA word is waiting for its reply.
    assign w_tx_load    = r_tx_armed && tx_valid && !SS_n;

    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign MISO     = w_miso;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: the selector bit routes the frame; SS_n high always aborts.
    always_comb begin
        w_next_state = r_state;
        if (SS_n) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE:      w_next_state = CHK_CMD;
                CHK_CMD: begin
                    if (!MOSI) begin
                        w_next_state = WRITE;
                    end else if (r_rd_addr_seen) begin
                        w_next_state = READ_DATA;
                    end else begin
                        w_next_state = READ_ADD;
                    end
                end
                WRITE,
                READ_ADD,
                READ_DATA: w_next_state = r_state;
                default:   w_next_state = IDLE;
            endcase
        end
    end

    // Receive shifter: rx_data only updates when a full word has arrived.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (SS_n) begin
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_rx_shift <= {r_rx_shift[MEM_WIDTH-1:0], MOSI};
                r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
                if (w_word_done) begin
                    r_rx_data  <= {r_rx_shift, MOSI};
                    r_rx_valid <= 1'b1;
                end
            end
        end
    end

    // Read handshake: remember the address phase and arm for the RAM reply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_addr_seen <= 1'b0;
            r_tx_armed     <= 1'b0;
        end else begin
            if (w_word_done && (r_state == READ_ADD)) begin
                r_rd_addr_seen <= 1'b1;
            end else if (w_tx_done) begin
                r_rd_addr_seen <= 1'b0;
            end

            if (SS_n || w_tx_load) begin
                r_tx_armed <= 1'b0;
            end else if (w_word_done && (r_state == READ_DATA)) begin
                r_tx_armed <= 1'b1;
            end
        end
    end

    spi_tx_serializer #(
        .WIDTH (MEM_WIDTH)
    ) u_tx_serializer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (SS_n),
        .i_load   (w_tx_load),
        .i_data   (tx_data),
        .o_serial (w_miso),
        .o_done   (w_tx_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_slave_ctrl
//  Purpose  : Directed, table-driven bench for spi_slave_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_slave_ctrl;

    import shared_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses  = 0;

    typedef struct {
        logic       sel;
        logic [9:0] word;
        int         nbits;
        int         extra;
        int         exp_pulses;
        logic [9:0] exp_data;
        logic       exp_seen;
        spi_state_e exp_state;
    } vec_t;

    vec_t vecs [6];

    spi_slave_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    // Count rx_valid pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) pulses++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drop SS_n, send selector and n word bits; returns at the negedge after the last bit edge.
    task automatic send_bits(input logic sel, input logic [9:0] w, input int n);
        @(negedge clk) SS_n = 1'b0; MOSI = 1'b1;
        @(negedge clk) MOSI = sel;
        for (int i = 0; i < n; i++) begin
            @(negedge clk) MOSI = w[9-i];
        end
        @(negedge clk);
    endtask

    initial begin
        vec_t       v;
        int         p0;
        logic [7:0] exp_tx;

        //            sel   word    n   ex pls data    seen  state
        vecs[0] = '{1'b0, 10'h0A5, 10, 3, 1, 10'h0A5, 1'b0, WRITE};
        vecs[1] = '{1'b0, 10'h13C, 10, 3, 1, 10'h13C, 1'b0, WRITE};
        vecs[2] = '{1'b1, 10'h205, 10, 3, 1, 10'h205, 1'b1, READ_ADD};
        vecs[3] = '{1'b0, 10'h07E, 10, 3, 1, 10'h07E, 1'b1, WRITE};
        vecs[4] = '{1'b0, 10'h3FF,  6, 0, 0, 10'h07E, 1'b1, WRITE};
        vecs[5] = '{1'b1, 10'h3AA, 10, 3, 1, 10'h3AA, 1'b1, READ_DATA};

        rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset MISO", MISO, 0);
        chk("reset rx_valid", rx_valid, 0);
        chk("reset rx_data", rx_data, 0);
        chk("reset state", 32'(dut.r_state), 32'(IDLE));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table: consecutive frames, routing state carried between rows.
        for (int i = 0; i < 6; i++) begin
            v  = vecs[i];
            p0 = pulses;
            send_bits(v.sel, v.word, v.nbits);
            chk($sformatf("v%0d rx_valid@12", i), rx_valid, (v.nbits == 10) ? 1 : 0);
            for (int k = 0; k < v.extra; k++) begin
                @(negedge clk) MOSI = ~MOSI;
            end
            chk($sformatf("v%0d state", i), 32'(dut.r_state), 32'(v.exp_state));
            @(negedge clk) SS_n = 1'b1;
            repeat (2) @(negedge clk);
            chk($sformatf("v%0d pulses", i), pulses - p0, v.exp_pulses);
            chk($sformatf("v%0d rx_data", i), rx_data, v.exp_data);
            chk($sformatf("v%0d rd_addr_seen", i), dut.r_rd_addr_seen, v.exp_seen);
            chk($sformatf("v%0d idle", i), 32'(dut.r_state), 32'(IDLE));
        end

        // Read data with MISO shifting; tx_valid during the word must be ignored.
        exp_tx = 8'hC3;
        @(negedge clk) SS_n = 1'b0; MOSI = 1'b1;
        @(negedge clk) MOSI = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk) MOSI = ((10'h3C0 >> (9 - i)) & 10'h1) != 0;
            if (i == 2) begin tx_valid = 1'b1; tx_data = 8'hFF; end
            if (i == 3) begin tx_valid = 1'b0; tx_data = 8'h00; end
        end
        @(negedge clk);
        chk("rd rx_valid", rx_valid, 1);
        chk("rd rx_data", rx_data, 10'h3C0);
        chk("rd early tx ignored", MISO, 0);
        tx_valid = 1'b1; tx_data = exp_tx;
        @(negedge clk) tx_valid = 1'b0; tx_data = 8'h00;
        chk("miso bit7", MISO, exp_tx[7]);
        for (int b = 6; b >= 0; b--) begin
            @(negedge clk);
            chk($sformatf("miso bit%0d", b), MISO, exp_tx[b]);
        end
        @(negedge clk);
        chk("miso trailing 0", MISO, 0);
        chk("rd seen cleared", dut.r_rd_addr_seen, 0);
        tx_valid = 1'b1; tx_data = 8'hFF;
        @(negedge clk) tx_valid = 1'b0; tx_data = 8'h00;
        @(negedge clk);
        chk("late tx ignored", MISO, 0);
        SS_n = 1'b1;
        repeat (2) @(negedge clk);

        // Abort while MISO is shifting keeps rd_addr_seen.
        send_bits(1'b1, 10'h205, 10);
        SS_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort pre seen", dut.r_rd_addr_seen, 1);
        send_bits(1'b1, 10'h3C0, 10);
        tx_valid = 1'b1; tx_data = 8'hC3;
        @(negedge clk) tx_valid = 1'b0; tx_data = 8'h00;
        chk("abort miso bit7", MISO, 1);
        @(negedge clk) SS_n = 1'b1;
        @(negedge clk);
        chk("abort miso 0", MISO, 0);
        chk("abort seen kept", dut.r_rd_addr_seen, 1);
        chk("abort idle", 32'(dut.r_state), 32'(IDLE));
        @(negedge clk);
        send_bits(1'b1, 10'h3FF, 2);
        chk("reenter READ_DATA", 32'(dut.r_state), 32'(READ_DATA));
        SS_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset in the middle of a frame.
        @(negedge clk) SS_n = 1'b0; MOSI = 1'b0;
        @(negedge clk) MOSI = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk) MOSI = 1'b1;
        end
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("midrst MISO", MISO, 0);
        chk("midrst rx_valid", rx_valid, 0);
        chk("midrst rx_data", rx_data, 0);
        chk("midrst seen", dut.r_rd_addr_seen, 0);
        chk("midrst state", 32'(dut.r_state), 32'(IDLE));
        SS_n = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        p0 = pulses;
        send_bits(1'b0, 10'h0A5, 10);
        chk("post-rst rx_valid", rx_valid, 1);
        chk("post-rst rx_data", rx_data, 10'h0A5);
        SS_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post-rst pulses", pulses - p0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
